// File: rtl/fifo_burst_reader.sv
// Read-side burst engine for a first-word-fall-through FIFO: drains fixed-length
// bursts (or a timed-out partial burst) into a registered valid/ready stream.
module fifo_burst_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int BURST_LEN  = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  fifo_rd_ena,
    input  logic [DATA_WIDTH-1:0] fifo_rd_dat,
    input  logic                  fifo_rd_empty,
    input  logic [ADDR_WIDTH:0]   fifo_dat_cnt,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_first,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  busy
);

    localparam int CNT_WIDTH   = ADDR_WIDTH + 1;
    localparam int TIMER_WIDTH = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_WIDTH-1:0]   BURST_CNT  = CNT_WIDTH'(BURST_LEN);
    localparam logic [CNT_WIDTH-1:0]   ONE_LEFT   = CNT_WIDTH'(1);
    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [TIMER_WIDTH-1:0] TIMER_ONE  = TIMER_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                 state_reg;
    logic [TIMER_WIDTH-1:0] timer_reg;
    logic [CNT_WIDTH-1:0]   fetch_left_reg;
    logic                   first_pending_reg;

    logic load;
    logic accept;
    logic full_ready;
    logic flush_ready;

    // A new word may enter the output register when it is empty or being emptied.
    assign accept      = m_valid && m_ready;
    assign load        = (state_reg == FETCH) && (fetch_left_reg != '0) && !fifo_rd_empty
                         && (!m_valid || m_ready);
    assign fifo_rd_ena = load;
    assign busy        = (state_reg != IDLE);

    assign full_ready  = (fifo_dat_cnt >= BURST_CNT);
    // A zero count with a stale non-empty flag must not latch an empty burst.
    assign flush_ready = (TIMEOUT != 0) && !fifo_rd_empty && (fifo_dat_cnt != '0)
                         && (timer_reg == TIMER_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg         <= IDLE;
            timer_reg         <= '0;
            fetch_left_reg    <= '0;
            first_pending_reg <= 1'b0;
            m_valid           <= 1'b0;
            m_data            <= '0;
            m_first           <= 1'b0;
            m_last            <= 1'b0;
        end else begin
            if (load) begin
                m_valid           <= 1'b1;
                m_data            <= fifo_rd_dat;
                m_first           <= first_pending_reg;
                m_last            <= (fetch_left_reg == ONE_LEFT);
                fetch_left_reg    <= fetch_left_reg - ONE_LEFT;
                first_pending_reg <= 1'b0;
            end else if (accept) begin
                m_valid <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (full_ready) begin
                        fetch_left_reg    <= BURST_CNT;
                        timer_reg         <= '0;
                        first_pending_reg <= 1'b1;
                        state_reg         <= FETCH;
                    end else if (fifo_rd_empty) begin
                        timer_reg <= '0;
                    end else if (flush_ready) begin
                        fetch_left_reg    <= fifo_dat_cnt;
                        timer_reg         <= '0;
                        first_pending_reg <= 1'b1;
                        state_reg         <= FETCH;
                    end else if (TIMEOUT != 0) begin
                        timer_reg <= timer_reg + TIMER_ONE;
                    end
                end
                FETCH: begin
                    if (load && (fetch_left_reg == ONE_LEFT)) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (accept && m_last) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Randomised bench for fifo_burst_reader: two instances (timeout 255 and 0) fed by
// behavioural FIFOs and checked against a burst-level reference model.
module tb_fifo_burst_reader;

    localparam int DW    = 16;
    localparam int AW    = 8;
    localparam int CW    = AW + 1;
    localparam int BL    = 16;
    localparam int TO0   = 255;
    localparam int NI    = 2;
    localparam int DEPTH = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [DW-1:0] rd_dat   [NI];
    logic          rd_empty [NI];
    logic [CW-1:0] dat_cnt  [NI];
    logic          rd_ena   [NI];
    logic          m_valid  [NI];
    logic [DW-1:0] m_data   [NI];
    logic          m_first  [NI];
    logic          m_last   [NI];
    logic          m_ready  [NI];
    logic          busy     [NI];

    fifo_burst_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL), .TIMEOUT(TO0)) dut (
        .clk(clk), .rst(rst),
        .fifo_rd_ena(rd_ena[0]), .fifo_rd_dat(rd_dat[0]), .fifo_rd_empty(rd_empty[0]),
        .fifo_dat_cnt(dat_cnt[0]),
        .m_valid(m_valid[0]), .m_data(m_data[0]), .m_first(m_first[0]), .m_last(m_last[0]),
        .m_ready(m_ready[0]), .busy(busy[0])
    );

    fifo_burst_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL), .TIMEOUT(0)) dut_nt (
        .clk(clk), .rst(rst),
        .fifo_rd_ena(rd_ena[1]), .fifo_rd_dat(rd_dat[1]), .fifo_rd_empty(rd_empty[1]),
        .fifo_dat_cnt(dat_cnt[1]),
        .m_valid(m_valid[1]), .m_data(m_data[1]), .m_first(m_first[1]), .m_last(m_last[1]),
        .m_ready(m_ready[1]), .busy(busy[1])
    );

    // FIFO contents double as the log of every word written, in order.
    logic [DW-1:0] mem [NI][DEPTH];
    int            wr_ptr [NI];
    int            rd_ptr [NI];
    int            wr_left [NI];
    logic [DW-1:0] next_word [NI];
    bit            rand_ready [NI];
    bit            pending_pop [NI];

    // Reference model: burst-level view of the engine.
    bit            mdl_idle [NI];
    int            idle_cnt [NI];
    int            burst_len [NI];
    int            beat_idx [NI];
    int            pops [NI];
    int            exp_start [NI];
    int            exp_idx [NI];
    bit            first_seen [NI];
    bit            prev_stall [NI];
    logic [DW-1:0] prev_data [NI];
    logic          prev_first [NI];
    logic          prev_last [NI];

    int cyc;
    int checks;
    int errors;
    bit rst_req;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int timeout_of(input int i);
        return (i == 0) ? TO0 : 0;
    endfunction

    task automatic start_burst(input int i, input int len);
        burst_len[i]  = len;
        beat_idx[i]   = 0;
        pops[i]       = 0;
        exp_start[i]  = cyc + 2;
        first_seen[i] = 1'b0;
        mdl_idle[i]   = 1'b0;
        idle_cnt[i]   = 0;
    endtask

    task automatic step();
        string u;
        int    cnt;
        @(negedge clk);
        cyc++;
        rst = rst_req;
        for (int i = 0; i < NI; i++) begin
            if (pending_pop[i]) rd_ptr[i]++;
            pending_pop[i] = 1'b0;
            if (wr_left[i] > 0) begin
                mem[i][wr_ptr[i]] = next_word[i];
                wr_ptr[i]++;
                next_word[i]++;
                wr_left[i]--;
            end
            dat_cnt[i]  = CW'(wr_ptr[i] - rd_ptr[i]);
            rd_empty[i] = (wr_ptr[i] == rd_ptr[i]);
            rd_dat[i]   = rd_empty[i] ? '0 : mem[i][rd_ptr[i]];
            m_ready[i]  = rand_ready[i] ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        #1;
        for (int i = 0; i < NI; i++) begin
            u = $sformatf("u%0d", i);
            if (rst) begin
                chk({u, ".rst_valid"}, 32'(m_valid[i]), 0);
                chk({u, ".rst_data"},  32'(m_data[i]),  0);
                chk({u, ".rst_first"}, 32'(m_first[i]), 0);
                chk({u, ".rst_last"},  32'(m_last[i]),  0);
                chk({u, ".rst_busy"},  32'(busy[i]),    0);
                chk({u, ".rst_rdena"}, 32'(rd_ena[i]),  0);
                mdl_idle[i]   = 1'b1;
                idle_cnt[i]   = 0;
                exp_idx[i]    = rd_ptr[i];
                prev_stall[i] = 1'b0;
                continue;
            end
            if (prev_stall[i]) begin
                chk({u, ".hold_valid"}, 32'(m_valid[i]), 1);
                chk({u, ".hold_data"},  32'(m_data[i]),  32'(prev_data[i]));
                chk({u, ".hold_first"}, 32'(m_first[i]), 32'(prev_first[i]));
                chk({u, ".hold_last"},  32'(m_last[i]),  32'(prev_last[i]));
            end
            chk({u, ".busy"}, 32'(busy[i]), 32'(!mdl_idle[i]));
            if (mdl_idle[i]) begin
                chk({u, ".valid_idle"}, 32'(m_valid[i]), 0);
                chk({u, ".rdena_idle"}, 32'(rd_ena[i]),  0);
                cnt = wr_ptr[i] - rd_ptr[i];
                if (cnt >= BL) begin
                    start_burst(i, BL);
                end else if (cnt > 0) begin
                    idle_cnt[i]++;
                    if (timeout_of(i) != 0 && idle_cnt[i] == timeout_of(i)) start_burst(i, cnt);
                end else begin
                    idle_cnt[i] = 0;
                end
            end else begin
                if (rd_ena[i]) begin
                    pops[i]++;
                    chk({u, ".pop_empty"}, 32'(rd_empty[i]), 0);
                end
                if (m_valid[i] && !first_seen[i]) begin
                    first_seen[i] = 1'b1;
                    chk({u, ".first_latency"}, 32'(cyc), 32'(exp_start[i]));
                end
                if (m_valid[i] && m_ready[i]) begin
                    chk({u, ".data"},  32'(m_data[i]),  32'(mem[i][exp_idx[i]]));
                    chk({u, ".first"}, 32'(m_first[i]), 32'(beat_idx[i] == 0));
                    chk({u, ".last"},  32'(m_last[i]),  32'(beat_idx[i] == burst_len[i] - 1));
                    exp_idx[i]++;
                    beat_idx[i]++;
                    if (beat_idx[i] == burst_len[i]) begin
                        chk({u, ".pops"}, 32'(pops[i]), 32'(burst_len[i]));
                        mdl_idle[i] = 1'b1;
                        $display("burst %s len=%0d ends cycle=%0d last=0x%04h", u, burst_len[i], cyc, m_data[i]);
                    end
                end
            end
            prev_stall[i]  = m_valid[i] && !m_ready[i];
            prev_data[i]   = m_data[i];
            prev_first[i]  = m_first[i];
            prev_last[i]   = m_last[i];
            pending_pop[i] = rd_ena[i];
        end
    endtask

    task automatic wait_done(input int i, input int budget);
        int n;
        bit done;
        n = 0;
        done = mdl_idle[i] && wr_left[i] == 0 && wr_ptr[i] == rd_ptr[i];
        while (!done && n < budget) begin
            step();
            n++;
            done = mdl_idle[i] && wr_left[i] == 0 && wr_ptr[i] == rd_ptr[i];
        end
        chk($sformatf("u%0d.wait_done", i), 32'(done), 1);
    endtask

    initial begin
        int t0;
        int n;
        cyc = 0; checks = 0; errors = 0;
        for (int i = 0; i < NI; i++) begin
            wr_ptr[i] = 0; rd_ptr[i] = 0; wr_left[i] = 0; next_word[i] = '0;
            rand_ready[i] = 1'b0; pending_pop[i] = 1'b0; mdl_idle[i] = 1'b1;
            idle_cnt[i] = 0; burst_len[i] = 0; beat_idx[i] = 0; pops[i] = 0;
            exp_start[i] = 0; exp_idx[i] = 0; first_seen[i] = 1'b0; prev_stall[i] = 1'b0;
            prev_data[i] = '0; prev_first[i] = 1'b0; prev_last[i] = 1'b0;
            rd_dat[i] = '0; rd_empty[i] = 1'b1; dat_cnt[i] = '0; m_ready[i] = 1'b1;
        end
        rst_req = 1'b1;
        repeat (2) step();
        rst_req = 1'b0;

        // Timeout-disabled instance: five words that must sit untouched.
        next_word[1] = 16'h0500; wr_left[1] = 5;

        // One full burst, ready held high.
        next_word[0] = 16'h0100; wr_left[0] = 16;
        wait_done(0, 300);

        // Two full bursts then an 8-word flush after the timeout.
        next_word[0] = 16'h0200; wr_left[0] = 40;
        wait_done(0, 1000);

        // Full burst under random back-pressure.
        rand_ready[0] = 1'b1;
        next_word[0] = 16'h0300; wr_left[0] = 16;
        wait_done(0, 600);
        rand_ready[0] = 1'b0;

        // Three words, a fourth 100 cycles after the first; timer must keep running.
        next_word[0] = 16'h0400; wr_left[0] = 3;
        t0 = cyc + 1;
        while (cyc < t0 + 99) step();
        wr_left[0] = 1;
        wait_done(0, 600);

        chk("u1.no_burst_cnt", 32'(wr_ptr[1] - rd_ptr[1]), 5);
        wr_left[1] = 11;
        wait_done(1, 300);

        // Reset five cycles into a burst, then let the leftovers flush.
        next_word[0] = 16'h0600; wr_left[0] = 16;
        n = 0;
        while (mdl_idle[0] && n < 100) begin
            step();
            n++;
        end
        chk("u0.burst_started", 32'(!mdl_idle[0]), 1);
        repeat (5) step();
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        wait_done(0, 800);
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
